// File: rtl/instr_pkg.sv
// Shared types, constants and helpers for the instrumentation output monitor.
package instr_pkg;

  localparam int CNT_W = 32;
  localparam logic [CNT_W-1:0] SAT_MAX = '1;
  localparam int FOLD_MAX_W = 1024;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    RUN        = 2'd2
  } mon_state_e;

  function automatic logic [31:0] rotl1(input logic [31:0] v);
    return {v[30:0], v[31]};
  endfunction

  // Callers zero-extend narrower data, which gives the zero-padded last slice.
  function automatic logic [31:0] fold32(input logic [FOLD_MAX_W-1:0] d);
    logic [31:0] f;
    f = '0;
    for (int i = 0; i < FOLD_MAX_W / 32; i++) f ^= d[i*32 +: 32];
    return f;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == SAT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/instr_output_monitor_if.sv
// AXI-Stream style handshake between the DUT output and the monitor sink.
interface instr_output_monitor_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/instr_sat_counter.sv
// Cycle counter with clear, restart-at-1 and saturating increment.
module instr_sat_counter
  import instr_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             restart_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)          cnt_d = '0;
    else if (restart_i) cnt_d = CNT_W'(1);
    else if (inc_i)     cnt_d = sat_inc(cnt_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/instr_output_monitor.sv
// Output-stream sink: measures first-beat latency, frame count, frame interval
// and a signature of the first completed frame.
module instr_output_monitor
  import instr_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int FRAME_BEATS = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  enable,
  input  logic                  in_first_beat,
  instr_output_monitor_if.slave s_axis,
  output logic [31:0]           status_o,
  output logic [31:0]           latency,
  output logic [31:0]           interval,
  output logic [31:0]           checksum,
  output logic                  checksum_valid
);

  localparam int BW = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(FRAME_BEATS - 1);

  mon_state_e       state_q, state_d;
  logic             en_q;
  logic             seen_q, seen_d;
  logic             ivl_run_q, ivl_run_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [CNT_W-1:0] status_q, status_d;
  logic [CNT_W-1:0] latency_q, latency_d;
  logic [CNT_W-1:0] interval_q, interval_d;
  logic [31:0]      chk_q, chk_d;
  logic             chk_vld_q, chk_vld_d;

  logic             lat_clr, lat_rst, lat_inc;
  logic             ivl_clr, ivl_rst, ivl_inc;
  logic [CNT_W-1:0] lat_cnt, ivl_cnt;
  logic             accept, first_ifb;
  logic [FOLD_MAX_W-1:0] tdata_w;

  assign s_axis.tready = (state_q != IDLE);
  assign accept        = s_axis.tvalid && s_axis.tready;

  always_comb begin
    tdata_w = '0;
    tdata_w[DATA_WIDTH-1:0] = s_axis.tdata;
  end

  always_comb begin
    state_d    = state_q;
    seen_d     = seen_q;
    ivl_run_d  = ivl_run_q;
    beat_d     = beat_q;
    status_d   = status_q;
    latency_d  = latency_q;
    interval_d = interval_q;
    chk_d      = chk_q;
    chk_vld_d  = chk_vld_q;
    lat_clr    = 1'b0;
    lat_rst    = 1'b0;
    lat_inc    = 1'b0;
    ivl_clr    = 1'b0;
    ivl_rst    = 1'b0;
    ivl_inc    = 1'b0;
    first_ifb  = 1'b0;

    // Disable wins over everything, including a handshake in the same cycle.
    if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!en_q) begin
            state_d    = WAIT_FIRST;
            seen_d     = 1'b0;
            ivl_run_d  = 1'b0;
            beat_d     = '0;
            status_d   = '0;
            latency_d  = '0;
            interval_d = '0;
            chk_d      = '0;
            chk_vld_d  = 1'b0;
            lat_clr    = 1'b1;
            ivl_clr    = 1'b1;
          end
        end
        WAIT_FIRST, RUN: begin
          if (state_q == WAIT_FIRST) begin
            first_ifb = in_first_beat && !seen_q;
            // Counter reads k in the k-th cycle after the first pulse.
            if (first_ifb) begin
              seen_d  = 1'b1;
              lat_rst = 1'b1;
            end else if (seen_q) begin
              lat_inc = 1'b1;
            end
            if (accept) begin
              state_d   = RUN;
              latency_d = first_ifb ? '0 : (seen_q ? lat_cnt : SAT_MAX);
            end
          end
          ivl_inc = ivl_run_q;
          if (accept) begin
            if (!chk_vld_q) chk_d = rotl1(chk_q) ^ fold32(tdata_w);
            if (beat_q == LAST_BEAT) begin
              beat_d    = '0;
              status_d  = sat_inc(status_q);
              chk_vld_d = 1'b1;
              ivl_rst   = 1'b1;
              ivl_run_d = 1'b1;
              if (ivl_run_q) interval_d = ivl_cnt;
            end else begin
              beat_d = beat_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      en_q       <= 1'b0;
      seen_q     <= 1'b0;
      ivl_run_q  <= 1'b0;
      beat_q     <= '0;
      status_q   <= '0;
      latency_q  <= '0;
      interval_q <= '0;
      chk_q      <= '0;
      chk_vld_q  <= 1'b0;
    end else begin
      en_q       <= enable;
      seen_q     <= seen_d;
      ivl_run_q  <= ivl_run_d;
      beat_q     <= beat_d;
      status_q   <= status_d;
      latency_q  <= latency_d;
      interval_q <= interval_d;
      chk_q      <= chk_d;
      chk_vld_q  <= chk_vld_d;
    end
  end

  instr_sat_counter u_lat_cnt (
    .clk_i     (ap_clk),
    .rst_ni    (ap_rst_n),
    .clr_i     (lat_clr),
    .restart_i (lat_rst),
    .inc_i     (lat_inc),
    .cnt_o     (lat_cnt)
  );

  instr_sat_counter u_ivl_cnt (
    .clk_i     (ap_clk),
    .rst_ni    (ap_rst_n),
    .clr_i     (ivl_clr),
    .restart_i (ivl_rst),
    .inc_i     (ivl_inc),
    .cnt_o     (ivl_cnt)
  );

  assign status_o       = status_q;
  assign latency        = latency_q;
  assign interval       = interval_q;
  assign checksum       = chk_q;
  assign checksum_valid = chk_vld_q;

endmodule
